// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : breakout_pkg
// Description : Shared state encodings and default constants for the
//               breakout game-flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
package breakout_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_SERVE = 2'd1,
        GS_PLAY  = 2'd2,
        GS_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_PADDLE  = 2'd1,
        SEQ_BALL    = 2'd2,
        SEQ_COLLIDE = 2'd3
    } seq_state_t;

    localparam int c_DEF_LIVES        = 3;
    localparam int c_DEF_SCORE_W      = 10;
    localparam int c_DEF_SERVE_FRAMES = 120;

endpackage
`default_nettype wire

// File: rtl/breakout_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : breakout_frame_seq
// Description : Per-frame step sequencer (paddle -> ball -> collide) with a
//               start/done handshake, end-of-frame strobe and sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module breakout_frame_seq
    import breakout_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_done,
    input  logic i_run_en,
    input  logic i_play_mode,
    output logic o_paddle_step,
    output logic o_ball_step,
    output logic o_collide_step,
    output logic o_seq_idle_stb,
    output logic o_overrun
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic       r_play_run;
    logic       w_play_run_nxt;
    logic       r_paddle_step;
    logic       r_ball_step;
    logic       r_collide_step;
    logic       r_idle_stb;
    logic       r_overrun;
    logic       w_paddle_nxt;
    logic       w_ball_nxt;
    logic       w_collide_nxt;
    logic       w_idle_stb_nxt;
    logic       w_overrun_nxt;
    logic       w_done_ok;

    // A done coinciding with a step pulse belongs to no started step.
    assign w_done_ok = i_done & ~(r_paddle_step | r_ball_step | r_collide_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= SEQ_IDLE;
            r_play_run     <= 1'b0;
            r_paddle_step  <= 1'b0;
            r_ball_step    <= 1'b0;
            r_collide_step <= 1'b0;
            r_idle_stb     <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_play_run     <= w_play_run_nxt;
            r_paddle_step  <= w_paddle_nxt;
            r_ball_step    <= w_ball_nxt;
            r_collide_step <= w_collide_nxt;
            r_idle_stb     <= w_idle_stb_nxt;
            r_overrun      <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_play_run_nxt = r_play_run;
        w_paddle_nxt   = 1'b0;
        w_ball_nxt     = 1'b0;
        w_collide_nxt  = 1'b0;
        w_idle_stb_nxt = 1'b0;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            SEQ_IDLE: begin
                if (i_tick && i_run_en) begin
                    w_state_nxt    = SEQ_PADDLE;
                    w_paddle_nxt   = 1'b1;
                    // Frame length is fixed at start so a mid-frame serve
                    // release cannot stretch a paddle-only frame.
                    w_play_run_nxt = i_play_mode;
                end
            end
            SEQ_PADDLE: begin
                if (w_done_ok) begin
                    if (r_play_run) begin
                        w_state_nxt = SEQ_BALL;
                        w_ball_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = SEQ_IDLE;
                        w_idle_stb_nxt = 1'b1;
                    end
                end
            end
            SEQ_BALL: begin
                if (w_done_ok) begin
                    w_state_nxt   = SEQ_COLLIDE;
                    w_collide_nxt = 1'b1;
                end
            end
            SEQ_COLLIDE: begin
                if (w_done_ok) begin
                    w_state_nxt    = SEQ_IDLE;
                    w_idle_stb_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase

        if (i_tick && (r_state != SEQ_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign o_paddle_step  = r_paddle_step;
    assign o_ball_step    = r_ball_step;
    assign o_collide_step = r_collide_step;
    assign o_seq_idle_stb = r_idle_stb;
    assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : breakout_game_ctrl
// Description : Breakout game-flow FSM, lives/score, event latches and frame
//               sequencing. Define BREAKOUT_AUTOSERVE_EN for timed auto-serve.
// Revision    : 1.0 - initial release
// ============================================================================
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int LIVES        = c_DEF_LIVES,
    parameter int SCORE_W      = c_DEF_SCORE_W,
    parameter int SERVE_FRAMES = c_DEF_SERVE_FRAMES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_frame_tick,
    input  logic               i_btn_select,
    input  logic               i_step_done,
    input  logic               i_ball_lost,
    input  logic               i_brick_hit,
    input  logic               i_bricks_clear,
    output logic               o_paddle_step,
    output logic               o_ball_step,
    output logic               o_collide_step,
    output logic               o_ball_reset,
    output logic               o_bricks_reset,
    output logic [1:0]         o_game_state,
    output logic [1:0]         o_lives,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_overrun
);

    localparam logic [1:0]         c_LIVES_INIT = 2'(LIVES);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX  = '1;

    game_state_t        r_state;
    game_state_t        w_state_nxt;
    logic [1:0]         r_lives;
    logic [1:0]         w_lives_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               r_ball_reset;
    logic               r_bricks_reset;
    logic               w_ball_reset_nxt;
    logic               w_bricks_reset_nxt;
    logic               r_lost_latch;
    logic               r_clear_latch;
    logic               w_lost_latch_nxt;
    logic               w_clear_latch_nxt;
    logic               r_btn_q;
    logic               w_sel_edge;
    logic               w_in_play;
    logic               w_lost;
    logic               w_clear;
    logic               w_seq_stb;
    logic               w_autoserve;

    assign w_sel_edge = i_btn_select & ~r_btn_q;
    assign w_in_play  = (r_state == GS_PLAY);
    assign w_lost     = r_lost_latch  | (i_ball_lost    & w_in_play);
    assign w_clear    = r_clear_latch | (i_bricks_clear & w_in_play);

    breakout_frame_seq u_frame_seq (
        .clk            (clk),
        .rst            (rst),
        .i_tick         (i_frame_tick),
        .i_done         (i_step_done),
        .i_run_en       ((r_state == GS_SERVE) || (r_state == GS_PLAY)),
        .i_play_mode    (w_in_play),
        .o_paddle_step  (o_paddle_step),
        .o_ball_step    (o_ball_step),
        .o_collide_step (o_collide_step),
        .o_seq_idle_stb (w_seq_stb),
        .o_overrun      (o_overrun)
    );

`ifdef BREAKOUT_AUTOSERVE_EN
    localparam logic [7:0] c_SERVE_LAST = 8'(SERVE_FRAMES - 1);

    logic [7:0] r_serve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_serve_cnt <= 8'd0;
        end else if ((w_state_nxt == GS_SERVE) && (r_state != GS_SERVE)) begin
            r_serve_cnt <= 8'd0;
        end else if ((r_state == GS_SERVE) && i_frame_tick) begin
            r_serve_cnt <= r_serve_cnt + 8'd1;
        end
    end

    assign w_autoserve = (r_state == GS_SERVE) && i_frame_tick &&
                         (r_serve_cnt == c_SERVE_LAST);
`else
    // SERVE_FRAMES is 1..255, so this folds to 0: SERVE exits on select only.
    assign w_autoserve = (SERVE_FRAMES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= GS_IDLE;
            r_lives        <= 2'd0;
            r_score        <= '0;
            r_ball_reset   <= 1'b0;
            r_bricks_reset <= 1'b0;
            r_lost_latch   <= 1'b0;
            r_clear_latch  <= 1'b0;
            r_btn_q        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_lives        <= w_lives_nxt;
            r_score        <= w_score_nxt;
            r_ball_reset   <= w_ball_reset_nxt;
            r_bricks_reset <= w_bricks_reset_nxt;
            r_lost_latch   <= w_lost_latch_nxt;
            r_clear_latch  <= w_clear_latch_nxt;
            r_btn_q        <= i_btn_select;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_lives_nxt        = r_lives;
        w_score_nxt        = r_score;
        w_ball_reset_nxt   = 1'b0;
        w_bricks_reset_nxt = 1'b0;
        w_lost_latch_nxt   = w_seq_stb ? 1'b0 : w_lost;
        w_clear_latch_nxt  = w_seq_stb ? 1'b0 : w_clear;

        case (r_state)
            GS_IDLE: begin
                if (w_sel_edge) begin
                    w_state_nxt        = GS_SERVE;
                    w_score_nxt        = '0;
                    w_lives_nxt        = c_LIVES_INIT;
                    w_ball_reset_nxt   = 1'b1;
                    w_bricks_reset_nxt = 1'b1;
                end
            end
            GS_SERVE: begin
                if (w_sel_edge || w_autoserve) begin
                    w_state_nxt = GS_PLAY;
                end
            end
            GS_PLAY: begin
                if (i_brick_hit && (r_score != c_SCORE_MAX)) begin
                    w_score_nxt = r_score + 1'b1;
                end
                // Ball/brick events only take effect once the frame's steps finish.
                if (w_seq_stb) begin
                    if (w_clear) begin
                        w_state_nxt        = GS_SERVE;
                        w_ball_reset_nxt   = 1'b1;
                        w_bricks_reset_nxt = 1'b1;
                    end else if (w_lost && (r_lives > 2'd1)) begin
                        w_state_nxt      = GS_SERVE;
                        w_lives_nxt      = r_lives - 2'd1;
                        w_ball_reset_nxt = 1'b1;
                    end else if (w_lost) begin
                        w_state_nxt = GS_OVER;
                        w_lives_nxt = 2'd0;
                    end
                end
            end
            GS_OVER: begin
                if (w_sel_edge) begin
                    w_state_nxt = GS_IDLE;
                end
            end
            default: begin
                w_state_nxt = GS_IDLE;
            end
        endcase
    end

    assign o_game_state   = r_state;
    assign o_lives        = r_lives;
    assign o_score        = r_score;
    assign o_ball_reset   = r_ball_reset;
    assign o_bricks_reset = r_bricks_reset;

endmodule
`default_nettype wire
